fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program counter (PC) and instruction register (IR) for the 8-bit SAP-style CPU.
- Sits directly under the control block:
  - consumes the PC and IR control strobes that the control block drives;
  - returns the 4-bit opcode to the control block.
- Drives the shared 8-bit bus through an explicit output-enable, not tri-states.
- Also holds the halt latch and a saturating fetch counter.

Parameters:
- PC_WIDTH, 4, PC and address width.
- DATA_WIDTH, 8, bus and IR width.
- OPCODE_HLT, 4'h0, opcode that sets the halt latch.
- IR_RESET, 8'h10, IR value after reset (NOP, operand 0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_inc  in  1  C_P, active-high: increment PC.
- pc_en  in  1  E_P, active-high: drive PC onto bus.
- pc_load  in  1  L_P, active-high: load PC from bus_in[PC_WIDTH-1:0].
- ir_load_n  in  1  \L_I, active-low: load IR from bus_in.
- ir_en_n  in  1  \E_I, active-low: drive IR operand onto bus.
- bus_in  in  DATA_WIDTH  current bus value.
- bus_out  out  DATA_WIDTH  value this block drives.
- bus_oe  out  1  high when bus_out is valid.
- bus_conflict  out  1  high when both drive sources are requested.
- opcode  out  4  IR[7:4], goes to the control block.
- operand  out  4  IR[3:0].
- pc_value  out  PC_WIDTH  current PC.
- halted  out  1  halt latch.
- fetch_count  out  8  number of IR loads, saturating.

Behaviour:
- Reset: synchronous. At a rising edge with rst=1:
  - PC=0, IR=IR_RESET, halted=0, fetch_count=0.
  - All other inputs are ignored that edge.
  - Outputs reflect the reset state from the following cycle.
  - Reset mid-instruction discards everything with no partial update.
- PC update, per edge, when not in reset and halted=0:
  - pc_load=1: PC <= bus_in[3:0]. Load has priority over pc_inc.
  - else pc_inc=1: PC <= PC+1, modulo 2^PC_WIDTH (15 -> 0, no flag).
  - else: hold.
- IR update, per edge, when not in reset and halted=0:
  - ir_load_n=0: IR <= bus_in.
  - If bus_in[7:4]==OPCODE_HLT, halted <= 1 at the same edge.
- fetch_count: increments at every edge that loads the IR; saturates at 255 (no wrap).
- Halt timing:
  - The edge that sets halted still applies that edge's pc_inc or pc_load.
  - From the next edge on, PC, IR and fetch_count are frozen.
  - halted clears only on rst.
- Bus drive is combinational from current registers and strobes:
  - pc_en=1 only: bus_oe=1, bus_out={4'h0, PC}.
  - ir_en_n=0 only: bus_oe=1, bus_out={4'h0, IR[3:0]}.
  - Both requested: bus_oe=1, bus_out=8'h00, bus_conflict=1. Registers are unaffected.
  - Neither requested: bus_oe=0, bus_out=8'h00, bus_conflict=0.
  - Bus drive remains active while halted.
- Same register driven and loaded in one cycle (e.g. pc_en with pc_load): bus shows the old value; the new value appears after the edge.
- opcode, operand and pc_value are direct register outputs; no added latency.
- Strobe sampling: the control block updates strobes on the falling edge, and this block samples on the rising edge. Every strobe therefore acts exactly once per cycle it is asserted.

Test Plan:
1. Reset then increment: rst=1 for 1 cycle, then pc_inc=1 for 17 cycles.
   -> pc_value 0,1,…,15,0,1; opcode=1, operand=0; halted=0.
2. Load priority: pc_load=1, pc_inc=1, bus_in=8'hFA.
   -> pc_value=4'hA next cycle. Then pc_en=1 -> bus_out=8'h0A, bus_oe=1.
3. IR load and drive: ir_load_n=0, bus_in=8'h2C.
   -> opcode=2, operand=C, fetch_count=1. Then ir_en_n=0 -> bus_out=8'h0C, bus_oe=1.
4. Conflict: pc_en=1 and ir_en_n=0 together.
   -> bus_out=8'h00, bus_conflict=1, bus_oe=1. Drop both -> bus_oe=0, bus_conflict=0.
5. Halt: PC=5; ir_load_n=0, bus_in=8'h03, pc_inc=1 on the same edge.
   -> halted=1, PC=6. Further pc_inc, pc_load and ir_load_n have no effect. rst=1 -> PC=0, IR=8'h10, halted=0.
6. Saturation and mid-run reset: 300 IR loads of 8'h10.
   -> fetch_count holds at 255. rst asserted together with pc_inc -> PC=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter, instruction register, halt latch and saturating fetch counter
// for the 8-bit SAP-style CPU; drives the shared bus through an explicit enable.
module fetch_unit #(
    parameter int unsigned                PC_WIDTH   = 4,
    parameter int unsigned                DATA_WIDTH = 8,
    parameter logic [3:0]                 OPCODE_HLT = 4'h0,
    parameter logic [DATA_WIDTH-1:0]      IR_RESET   = 'h10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_inc,
    input  logic                  pc_en,
    input  logic                  pc_load,
    input  logic                  ir_load_n,
    input  logic                  ir_en_n,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  bus_conflict,
    output logic [3:0]            opcode,
    output logic [3:0]            operand,
    output logic [PC_WIDTH-1:0]   pc_value,
    output logic                  halted,
    output logic [7:0]            fetch_count
);

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  halted_q, halted_d;
    logic [7:0]            cnt_q, cnt_d;

    // The edge that sets the halt latch still applies its own PC update.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (!halted_q) begin
            if (pc_load) begin
                pc_d = bus_in[PC_WIDTH-1:0];
            end else if (pc_inc) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
            if (!ir_load_n) begin
                ir_d = bus_in;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (bus_in[DATA_WIDTH-1 -: 4] == OPCODE_HLT) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= IR_RESET;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        bus_out      = '0;
        bus_oe       = 1'b0;
        bus_conflict = 1'b0;
        if (pc_en && !ir_en_n) begin
            bus_oe       = 1'b1;
            bus_conflict = 1'b1;
        end else if (pc_en) begin
            bus_oe  = 1'b1;
            bus_out = DATA_WIDTH'(pc_q);
        end else if (!ir_en_n) begin
            bus_oe  = 1'b1;
            bus_out = DATA_WIDTH'(ir_q[3:0]);
        end
    end

    assign opcode      = ir_q[DATA_WIDTH-1 -: 4];
    assign operand     = ir_q[3:0];
    assign pc_value    = pc_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver predicts each cycle's bus and
// post-edge register state from a behavioural model; a monitor pops and compares.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pc_inc = 1'b0, pc_en = 1'b0, pc_load = 1'b0;
    logic       ir_load_n = 1'b1, ir_en_n = 1'b1;
    logic [7:0] bus_in = '0;
    logic [7:0] bus_out;
    logic       bus_oe, bus_conflict;
    logic [3:0] opcode, operand, pc_value;
    logic       halted;
    logic [7:0] fetch_count;

    fetch_unit #(
        .PC_WIDTH  (4),
        .DATA_WIDTH(8),
        .OPCODE_HLT(4'h0),
        .IR_RESET  (8'h10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_inc      (pc_inc),
        .pc_en       (pc_en),
        .pc_load     (pc_load),
        .ir_load_n   (ir_load_n),
        .ir_en_n     (ir_en_n),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .bus_conflict(bus_conflict),
        .opcode      (opcode),
        .operand     (operand),
        .pc_value    (pc_value),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bus_out;
        int bus_oe;
        int conflict;
        int pc;
        int ir;
        int halted;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state kept as plain integers.
    int m_pc = 0, m_ir = 0, m_halt = 0, m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit inc, input bit en, input bit ld,
                        input bit irl_n, input bit ire_n, input int b);
        exp_t e;
        @(negedge clk);
        rst = r; pc_inc = inc; pc_en = en; pc_load = ld;
        ir_load_n = irl_n; ir_en_n = ire_n; bus_in = 8'(b);
        e.bus_oe   = (en || !ire_n) ? 1 : 0;
        e.conflict = (en && !ire_n) ? 1 : 0;
        if (en && !ire_n)  e.bus_out = 0;
        else if (en)       e.bus_out = m_pc;
        else if (!ire_n)   e.bus_out = m_ir % 16;
        else               e.bus_out = 0;
        if (r) begin
            m_pc = 0; m_ir = 'h10; m_halt = 0; m_cnt = 0;
        end else if (m_halt == 0) begin
            if (ld)       m_pc = b % 16;
            else if (inc) m_pc = (m_pc + 1) % 16;
            if (!irl_n) begin
                m_ir  = b % 256;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_ir / 16 == 0) m_halt = 1;
            end
        end
        e.pc = m_pc; e.ir = m_ir; e.halted = m_halt; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle(input int b);
        step(0, 0, 0, 0, 1, 1, b);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("bus_out", int'(bus_out), e.bus_out);
                chk("bus_oe", int'(bus_oe), e.bus_oe);
                chk("bus_conflict", int'(bus_conflict), e.conflict);
                @(posedge clk);
                #1;
                chk("pc_value", int'(pc_value), e.pc);
                chk("opcode", int'(opcode), e.ir / 16);
                chk("operand", int'(operand), e.ir % 16);
                chk("halted", int'(halted), e.halted);
                chk("fetch_count", int'(fetch_count), e.cnt);
            end
        end
    end

    initial begin : driver
        // 1: reset, then 17 increments to see the wrap
        step(1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 1, 1, 0);
        // 2: load beats increment, then drive PC
        step(0, 1, 0, 1, 1, 1, 'hFA);
        step(0, 0, 1, 0, 1, 1, 0);
        // 3: IR load, then drive operand
        step(0, 0, 0, 0, 0, 1, 'h2C);
        step(0, 0, 0, 0, 1, 0, 0);
        // 4: conflict, then release
        step(0, 0, 1, 0, 1, 0, 0);
        idle(0);
        // same-cycle drive and load shows old value
        step(0, 0, 1, 1, 1, 1, 'h07);
        step(0, 0, 1, 0, 1, 1, 0);
        // 5: halt with simultaneous increment, then frozen state
        step(0, 0, 0, 1, 1, 1, 'h05);
        step(0, 1, 0, 0, 0, 1, 'h03);
        step(0, 1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 'h09);
        step(0, 0, 0, 0, 0, 1, 'h4B);
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        idle(0);
        // 6: saturation, then reset together with increment
        for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 1, 'h10);
        step(1, 1, 0, 0, 1, 1, 0);
        idle(0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 255)));
        end
        idle(0);
        @(posedge clk);
        #5;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
